// File: rtl/lcd_pkg.sv
// Shared HD44780 constants: request modes, sequencer states, status-byte fields.
// Both the writer and the reader sequencers import this package.
package lcd_pkg;

  localparam logic [1:0] MODE_BFAC = 2'd0;
  localparam logic [1:0] MODE_DATA = 2'd1;
  localparam logic [1:0] MODE_POLL = 2'd2;

  localparam int BF_BIT = 7;
  localparam int AC_MSB = 6;
  localparam int AC_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_RECOVER,
    ST_DONE
  } lcd_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Request/status and LCD pin bundle for the read sequencer.
// master = requester side, slave = the lcd_reader itself.
interface lcd_reader_if;

  logic       start;
  logic [1:0] mode;
  logic [7:0] lcd_data_in;
  logic       EN;
  logic       RW;
  logic       RS;
  logic       owns_bus;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       bf;
  logic [6:0] ac;
  logic [7:0] rd_data;

  modport master (
    output start, mode, lcd_data_in,
    input  EN, RW, RS, owns_bus, busy,
    input  done, timeout, bf, ac, rd_data
  );

  modport slave (
    input  start, mode, lcd_data_in,
    output EN, RW, RS, owns_bus, busy,
    output done, timeout, bf, ac, rd_data
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with terminal-count flag for EN phase sequencing.
// Holds at zero once expired; a load always takes priority.
module lcd_phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read sequencer: BF/AC read, data read, or polled busy-flag wait.
// All pin and status outputs come straight from flops.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int EN_CYCLES    = 50000,
  parameter int MAX_POLLS    = 255
) (
  input logic         clk,
  input logic         rst,
  lcd_reader_if.slave bus
);

  localparam int TW = $clog2(max2(SETUP_CYCLES, EN_CYCLES) + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);

  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] EN_LD    = TW'(EN_CYCLES - 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);

  lcd_state_e state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] polls_q, polls_d;
  logic en_q, en_d;
  logic rw_q, rw_d;
  logic rs_q, rs_d;
  logic own_q, own_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic to_q, to_d;
  logic bf_q, bf_d;
  logic [6:0] ac_q, ac_d;
  logic [7:0] rd_q, rd_d;

  logic          ld;
  logic [TW-1:0] ld_val;
  logic          tc;
  logic          again;

  lcd_phase_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .tc       (tc)
  );

  // polls_q counts reads completed in this transaction
  assign again = (mode_q == MODE_POLL) && bf_q &&
                 (polls_q < POLL_MAX);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    polls_d = polls_q;
    en_d    = en_q;
    rw_d    = rw_q;
    rs_d    = rs_q;
    own_d   = own_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    to_d    = to_q;
    bf_d    = bf_q;
    ac_d    = ac_q;
    rd_d    = rd_q;
    ld      = 1'b0;
    ld_val  = SETUP_LD;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETUP;
          mode_d  = (bus.mode == MODE_DATA ||
                     bus.mode == MODE_POLL) ?
                    bus.mode : MODE_BFAC;
          rs_d    = (bus.mode == MODE_DATA);
          rw_d    = 1'b1;
          own_d   = 1'b1;
          busy_d  = 1'b1;
          to_d    = 1'b0;
          polls_d = '0;
          ld      = 1'b1;
          ld_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tc) begin
          state_d = ST_PULSE;
          en_d    = 1'b1;
          ld      = 1'b1;
          ld_val  = EN_LD;
        end
      end
      ST_PULSE: begin
        if (tc) begin
          state_d = ST_RECOVER;
          en_d    = 1'b0;
          ld      = 1'b1;
          ld_val  = EN_LD;
          polls_d = (polls_q == POLL_MAX) ?
                    polls_q : polls_q + 1'b1;
          if (rs_q) begin
            rd_d = bus.lcd_data_in;
          end else begin
            bf_d = bus.lcd_data_in[BF_BIT];
            ac_d = bus.lcd_data_in[AC_MSB:AC_LSB];
          end
        end
      end
      ST_RECOVER: begin
        if (tc) begin
          if (again) begin
            state_d = ST_SETUP;
            ld      = 1'b1;
            ld_val  = SETUP_LD;
          end else begin
            state_d = ST_DONE;
            to_d    = (mode_q == MODE_POLL) && bf_q;
            done_d  = 1'b1;
            rw_d    = 1'b0;
            rs_d    = 1'b0;
            own_d   = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BFAC;
      polls_q <= '0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      rs_q    <= 1'b0;
      own_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      bf_q    <= 1'b1;
      ac_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      polls_q <= polls_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
      own_q   <= own_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      bf_q    <= bf_d;
      ac_q    <= ac_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.EN       = en_q;
  assign bus.RW       = rw_q;
  assign bus.RS       = rs_q;
  assign bus.owns_bus = own_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.timeout  = to_q;
  assign bus.bf       = bf_q;
  assign bus.ac       = ac_q;
  assign bus.rd_data  = rd_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: vector table driven through a scoreboard,
// plus hand sequences for reset, ignored starts and rst/start collision.
module tb_lcd_reader;

  localparam int S   = 2;
  localparam int E   = 4;
  localparam int MP  = 3;
  localparam int BLK = S + 2 * E;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lcd_reader_if bus();

  lcd_reader #(
    .SETUP_CYCLES (S),
    .EN_CYCLES    (E),
    .MAX_POLLS    (MP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] dat;
    int          ncyc;
    int          npulse;
    logic        rs;
    logic        bf;
    logic [6:0]  ac;
    logic [7:0]  rd;
    logic        to;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input bit repulse);
    int   pulses;
    bit   prev_en;
    bit   got;
    int   pos;
    vec_t e;
    sb.push_back(v);
    bus.mode        = v.mode;
    bus.lcd_data_in = v.dat[7:0];
    bus.start       = 1'b1;
    tick();
    pulses  = 0;
    prev_en = 1'b0;
    got     = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      bus.start = 1'b0;
      if (prev_en && !bus.EN) begin
        pulses++;
        if (pulses < 3) bus.lcd_data_in = v.dat[8*pulses +: 8];
      end
      prev_en = bus.EN;
      if (bus.done) begin
        got = 1'b1;
        e   = sb.pop_front();
        chk("done_cycle", c, e.ncyc);
        chk("en_pulses", pulses, e.npulse);
        chk("bf", bus.bf, e.bf);
        chk("ac", bus.ac, e.ac);
        chk("rd_data", bus.rd_data, e.rd);
        chk("timeout", bus.timeout, e.to);
        chk("rw_at_done", bus.RW, 0);
        chk("rs_at_done", bus.RS, 0);
        chk("owns_at_done", bus.owns_bus, 0);
        chk("busy_at_done", bus.busy, 1);
      end else begin
        pos = (c - 1) % BLK + 1;
        chk("en_phase", bus.EN, (pos > S && pos <= S + E));
        chk("rw_txn", bus.RW, 1);
        chk("rs_txn", bus.RS, v.rs);
        chk("owns_txn", bus.owns_bus, 1);
        chk("busy_txn", bus.busy, 1);
        chk("timeout_txn", bus.timeout, 0);
        if (repulse && (c == 3 || c == 8)) begin
          bus.start = 1'b1;
          bus.mode  = 2'd0;
        end
        tick();
      end
    end
    if (!got) begin
      chk("done_seen", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    tick();
    chk("busy_after", bus.busy, 0);
    chk("done_once", bus.done, 0);
    tick();
    chk("timeout_hold", bus.timeout, v.to);
    chk("done_quiet", bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{2'd0, 24'h0000A5, 11, 1, 1'b0, 1'b1, 7'h25, 8'h00, 1'b0};
    vecs[1] = '{2'd1, 24'h000041, 11, 1, 1'b1, 1'b1, 7'h25, 8'h41, 1'b0};
    vecs[2] = '{2'd2, 24'h058080, 31, 3, 1'b0, 1'b0, 7'h05, 8'h41, 1'b0};
    vecs[3] = '{2'd2, 24'hFFFFFF, 31, 3, 1'b0, 1'b1, 7'h7F, 8'h41, 1'b1};
    vecs[4] = '{2'd3, 24'h000012, 11, 1, 1'b0, 1'b0, 7'h12, 8'h41, 1'b0};
    vecs[5] = '{2'd2, 24'h000033, 11, 1, 1'b0, 1'b0, 7'h33, 8'h41, 1'b0};
    vecs[6] = '{2'd1, 24'h000099, 11, 1, 1'b1, 1'b0, 7'h33, 8'h99, 1'b0};

    bus.start       = 1'b0;
    bus.mode        = 2'd0;
    bus.lcd_data_in = 8'h00;
    rst             = 1'b1;
    repeat (3) tick();
    chk("rst_en", bus.EN, 0);
    chk("rst_rw", bus.RW, 0);
    chk("rst_rs", bus.RS, 0);
    chk("rst_owns", bus.owns_bus, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_bf", bus.bf, 1);
    chk("rst_ac", bus.ac, 0);
    chk("rst_rd", bus.rd_data, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b0);

    v = '{2'd1, 24'h00005A, 11, 1, 1'b1, 1'b0, 7'h33, 8'h5A, 1'b0};
    run_txn(v, 1'b1);

    bus.start = 1'b1;
    bus.mode  = 2'd1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("collide_busy", bus.busy, 0);
    chk("collide_rw", bus.RW, 0);
    chk("collide_bf", bus.bf, 1);
    chk("collide_rd", bus.rd_data, 0);
    tick();
    chk("collide_idle", bus.busy, 0);

    bus.mode        = 2'd0;
    bus.lcd_data_in = 8'hC3;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("mid_en_high", bus.EN, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_en", bus.EN, 0);
    chk("mid_rw", bus.RW, 0);
    chk("mid_owns", bus.owns_bus, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_bf", bus.bf, 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("mid_no_done", bus.done, 0);
    end

    v = '{2'd0, 24'h000007, 11, 1, 1'b0, 1'b0, 7'h07, 8'h00, 1'b0};
    run_txn(v, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
